// File: rtl/serpent_xts_sector_ctrl.sv
// XTS sector sequencer wrapped around a single pipelined Serpent core.
// It pre-whitens each block with the running tweak and issues it to the core.
// The tweak is held in a small FIFO until the core returns the block, then the
// same tweak post-whitens it. The tweak advances by alpha in GF(2^128),
// using the little-endian byte order of IEEE 1619.
module serpent_xts_sector_ctrl #(
    parameter int LEN_W        = 9,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_decrypt,
    input  logic [127:0]     i_tweak,
    input  logic [LEN_W-1:0] i_num_blocks,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    input  logic [127:0]     i_data,
    output logic             o_data_valid,
    output logic [127:0]     o_data,
    output logic             o_data_last,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err,
    output logic             o_core_valid,
    output logic [127:0]     o_core_data,
    output logic             o_core_decrypt,
    input  logic             i_core_valid,
    input  logic [127:0]     i_core_data
);
    localparam int               PTR_W = $clog2(MAX_INFLIGHT);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(MAX_INFLIGHT);
    localparam logic [LEN_W:0]   ONE   = {{LEN_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [LEN_W-1:0]   r_num;
    logic               r_dec;
    logic [127:0]       r_tweak;
    logic [LEN_W:0]     r_issued, r_retired;
    logic [127:0]       r_fifo [MAX_INFLIGHT];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_core_valid, r_out_valid, r_out_last, r_done, r_err;
    logic [127:0]       r_core_data, r_out_data;

    logic [LEN_W:0]     w_num_ext;
    logic               w_ready, w_push, w_pop, w_last, w_empty, w_start;

    // Byte 0 sits in the top byte of the bus; the GF math wants it in the LSB.
    function automatic logic [127:0] byte_rev(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] mul_alpha(input logic [127:0] t);
        logic [127:0] l, ls;
        l  = byte_rev(t);
        ls = {l[126:0], 1'b0} ^ (l[127] ? 128'h87 : 128'h0);
        return byte_rev(ls);
    endfunction

    // Ready comes only from registered state, so a pop in this cycle frees
    // its FIFO slot one cycle later.
    assign w_num_ext = {1'b0, r_num};
    assign w_empty   = (r_count == '0);
    assign w_ready   = (r_state == S_RUN) && (r_issued < w_num_ext) && (r_count < FULL);
    assign w_push    = w_ready && i_data_valid;
    assign w_pop     = i_core_valid && !w_empty;
    assign w_last    = w_pop && ((r_retired + ONE) == w_num_ext);
    assign w_start   = (r_state == S_IDLE) && i_start;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_num_blocks == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, sector parameters, tweak chain and block counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_dec     <= 1'b0;
            r_tweak   <= '0;
            r_issued  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_num     <= i_num_blocks;
                r_dec     <= i_decrypt;
                r_tweak   <= i_tweak;
                r_issued  <= '0;
                r_retired <= '0;
            end else begin
                if (w_push) begin
                    r_tweak  <= mul_alpha(r_tweak);
                    r_issued <= r_issued + ONE;
                end
                if (w_pop) r_retired <= r_retired + ONE;
            end
        end
    end

    // Tweak FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tweak FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wptr] <= r_tweak;
    end

    // Registered outputs: core issue, post-whitened result, done and error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_core_valid <= 1'b0;
            r_core_data  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_core_valid <= w_push;
            if (w_push) r_core_data <= i_data ^ r_tweak;
            r_out_valid  <= w_pop;
            if (w_pop)  r_out_data  <= i_core_data ^ r_fifo[r_rptr];
            r_out_last   <= w_last;
            r_done       <= (r_state == S_DONE);
            // A result with no tweak waiting is unmatched; drop it and flag it.
            r_err        <= r_err | (i_core_valid && w_empty);
        end
    end

    assign o_data_ready   = w_ready;
    assign o_data_valid   = r_out_valid;
    assign o_data         = r_out_data;
    assign o_data_last    = r_out_last;
    assign o_done         = r_done;
    assign o_busy         = (r_state != S_IDLE);
    assign o_err          = r_err;
    assign o_core_valid   = r_core_valid;
    assign o_core_data    = r_core_data;
    assign o_core_decrypt = r_dec;
endmodule
